// File: rtl/rng_pkg.sv
// Shared constants and FSM encoding for the random-byte burst scheduler.
package rng_pkg;

    localparam int BYTE_W = 8;

    localparam int                DEFAULT_BURST_LEN = 16;
    localparam logic [BYTE_W-1:0] DEFAULT_HEADER    = 8'hA5;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_HDR       = 4'd1;
    localparam logic [3:0] ST_HDR_WAIT  = 4'd2;
    localparam logic [3:0] ST_REQ       = 4'd3;
    localparam logic [3:0] ST_RNG_WAIT  = 4'd4;
    localparam logic [3:0] ST_SEND      = 4'd5;
    localparam logic [3:0] ST_SEND_WAIT = 4'd6;
    localparam logic [3:0] ST_CSUM      = 4'd7;
    localparam logic [3:0] ST_CSUM_WAIT = 4'd8;

    typedef enum logic [3:0] {
        IDLE      = ST_IDLE,
        HDR       = ST_HDR,
        HDR_WAIT  = ST_HDR_WAIT,
        REQ       = ST_REQ,
        RNG_WAIT  = ST_RNG_WAIT,
        SEND      = ST_SEND,
        SEND_WAIT = ST_SEND_WAIT,
        CSUM      = ST_CSUM,
        CSUM_WAIT = ST_CSUM_WAIT
    } state_t;

endpackage

// File: rtl/rng_burst_scheduler.sv
// Frames random bytes for the UART: header, BURST_LEN fetched bytes, XOR checksum,
// handshaking each byte with the UART completion pulse.
module rng_burst_scheduler
    import rng_pkg::*;
#(
    parameter int                BURST_LEN = DEFAULT_BURST_LEN,
    parameter logic [BYTE_W-1:0] HEADER    = DEFAULT_HEADER
) (
    input  logic              sys_Clk,
    input  logic              reset,
    input  logic              button,
    input  logic              rng_Valid,
    input  logic [BYTE_W-1:0] rng_Byte,
    output logic              rng_Req,
    input  logic              uart_Done,
    output logic              uart_Wr,
    output logic [BYTE_W-1:0] uart_Data,
    output logic              busy,
    output logic [BYTE_W-1:0] drop_Cnt
);

    localparam logic [BYTE_W-1:0] BURST_LEN_B = BYTE_W'(BURST_LEN);
    localparam logic [BYTE_W-1:0] DROP_MAX    = '1;

    state_t            state_reg;
    logic              btn_q;
    logic              mask_reg;
    logic [BYTE_W-1:0] cnt_reg;
    logic [BYTE_W-1:0] csum_reg;
    logic              rng_req_reg;
    logic              uart_wr_reg;
    logic [BYTE_W-1:0] uart_data_reg;
    logic              busy_reg;
    logic [BYTE_W-1:0] drop_cnt_reg;
    logic              start;

    // mask_reg blocks a button that was already high when reset released
    assign start = button & ~btn_q & ~mask_reg;

    always_ff @(posedge sys_Clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            btn_q         <= 1'b0;
            mask_reg      <= 1'b1;
            cnt_reg       <= '0;
            csum_reg      <= '0;
            rng_req_reg   <= 1'b0;
            uart_wr_reg   <= 1'b0;
            uart_data_reg <= '0;
            busy_reg      <= 1'b0;
            drop_cnt_reg  <= '0;
        end else begin
            btn_q       <= button;
            mask_reg    <= 1'b0;
            rng_req_reg <= 1'b0;
            uart_wr_reg <= 1'b0;

            if (rng_Valid && state_reg != RNG_WAIT && drop_cnt_reg != DROP_MAX)
                drop_cnt_reg <= drop_cnt_reg + 8'd1;

            case (state_reg)
                IDLE: begin
                    cnt_reg  <= '0;
                    csum_reg <= '0;
                    if (start) begin
                        state_reg <= HDR;
                        busy_reg  <= 1'b1;
                    end
                end
                HDR: begin
                    uart_data_reg <= HEADER;
                    uart_wr_reg   <= 1'b1;
                    state_reg     <= HDR_WAIT;
                end
                HDR_WAIT: begin
                    if (uart_Done)
                        state_reg <= REQ;
                end
                REQ: begin
                    rng_req_reg <= 1'b1;
                    state_reg   <= RNG_WAIT;
                end
                RNG_WAIT: begin
                    if (rng_Valid) begin
                        uart_data_reg <= rng_Byte;
                        csum_reg      <= csum_reg ^ rng_Byte;
                        cnt_reg       <= cnt_reg + 8'd1;
                        state_reg     <= SEND;
                    end
                end
                SEND: begin
                    uart_wr_reg <= 1'b1;
                    state_reg   <= SEND_WAIT;
                end
                SEND_WAIT: begin
                    if (uart_Done)
                        state_reg <= (cnt_reg < BURST_LEN_B) ? REQ : CSUM;
                end
                CSUM: begin
                    uart_data_reg <= csum_reg;
                    uart_wr_reg   <= 1'b1;
                    state_reg     <= CSUM_WAIT;
                end
                CSUM_WAIT: begin
                    if (uart_Done) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign rng_Req   = rng_req_reg;
    assign uart_Wr   = uart_wr_reg;
    assign uart_Data = uart_data_reg;
    assign busy      = busy_reg;
    assign drop_Cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_rng_burst_scheduler.sv
// Randomised and directed check of the burst scheduler against a frame-level model.
`timescale 1ns/1ps
module tb_rng_burst_scheduler;

    localparam int         BL  = 4;
    localparam logic [7:0] HDR = 8'hA5;

    logic       sys_Clk = 1'b0;
    logic       reset;
    logic       button;
    logic       rng_Valid;
    logic [7:0] rng_Byte;
    logic       rng_Req;
    logic       uart_Done;
    logic       uart_Wr;
    logic [7:0] uart_Data;
    logic       busy;
    logic [7:0] drop_Cnt;

    logic       b1_button, b1_valid, b1_done;
    logic [7:0] b1_byte;
    logic       b1_req, b1_wr, b1_busy;
    logic [7:0] b1_data, b1_drop;

    always #5 sys_Clk = ~sys_Clk;

    rng_burst_scheduler #(.BURST_LEN(BL), .HEADER(HDR)) u_dut (
        .sys_Clk(sys_Clk), .reset(reset), .button(button),
        .rng_Valid(rng_Valid), .rng_Byte(rng_Byte), .rng_Req(rng_Req),
        .uart_Done(uart_Done), .uart_Wr(uart_Wr), .uart_Data(uart_Data),
        .busy(busy), .drop_Cnt(drop_Cnt)
    );

    rng_burst_scheduler #(.BURST_LEN(1), .HEADER(HDR)) u_dut1 (
        .sys_Clk(sys_Clk), .reset(reset), .button(b1_button),
        .rng_Valid(b1_valid), .rng_Byte(b1_byte), .rng_Req(b1_req),
        .uart_Done(b1_done), .uart_Wr(b1_wr), .uart_Data(b1_data),
        .busy(b1_busy), .drop_Cnt(b1_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h required %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge sys_Clk);
        #1;
    endtask

    // ---------------- behavioural model (frame level, one-edge action pipeline) ----------------
    // waiting: 0 nothing, 1 UART completion, 2 random byte
    // pending action for the next edge: 0 none, 1 header write, 2 request, 3 data write, 4 checksum write
    int         cyc = 0;
    int         last_done_edge = -1;
    bit         m_active, m_mask, m_btn_prev;
    int         m_wait, m_pend, m_last, m_n;
    logic [7:0] m_csum, m_data, m_drop;
    logic       m_wr, m_req;

    always @(posedge sys_Clk) begin
        int  emit;
        bit  start, was_active;
        cyc++;
        if (!reset) begin
            m_active = 0; m_mask = 1; m_btn_prev = 0;
            m_wait = 0; m_pend = 0; m_last = 0; m_n = 0;
            m_csum = 0; m_data = 0; m_drop = 0; m_wr = 0; m_req = 0;
        end else begin
            if (uart_Done) last_done_edge = cyc;
            emit       = m_pend;
            m_pend     = 0;
            m_wr       = 0;
            m_req      = 0;
            start      = button && !m_btn_prev && !m_mask;
            m_btn_prev = button;
            m_mask     = 0;
            was_active = m_active;

            if (rng_Valid && m_wait == 2) begin
                m_data = rng_Byte;
                m_csum = m_csum ^ rng_Byte;
                m_n++;
                m_wait = 0;
                m_pend = 3;
            end else if (rng_Valid && m_drop != 8'hFF) begin
                m_drop = m_drop + 8'd1;
            end

            if (uart_Done && m_wait == 1) begin
                m_wait = 0;
                if (m_last == 1)      m_pend = 2;
                else if (m_last == 3) m_pend = (m_n < BL) ? 2 : 4;
                else                  m_active = 0;
            end

            if (start && !was_active) begin
                m_active = 1;
                m_n      = 0;
                m_csum   = 0;
                m_pend   = 1;
            end

            case (emit)
                1: begin m_wr = 1; m_data = HDR;    m_wait = 1; m_last = 1; end
                2: begin m_req = 1;                 m_wait = 2;             end
                3: begin m_wr = 1;                  m_wait = 1; m_last = 3; end
                4: begin m_wr = 1; m_data = m_csum; m_wait = 1; m_last = 4; end
                default: ;
            endcase
        end
    end

    // ---------------- compare process ----------------
    logic [7:0] wr_log[$];
    int         last_wr_cyc  = -1;
    int         last_req_cyc = -1;

    always @(negedge sys_Clk) begin
        check("rng_Req",   {7'd0, rng_Req}, {7'd0, m_req});
        check("uart_Wr",   {7'd0, uart_Wr}, {7'd0, m_wr});
        check("uart_Data", uart_Data, m_data);
        check("busy",      {7'd0, busy},    {7'd0, m_active});
        check("drop_Cnt",  drop_Cnt, m_drop);
        if (uart_Wr) begin
            wr_log.push_back(uart_Data);
            last_wr_cyc = cyc;
            $display("uart write #%0d data=%02h cycle=%0d drops=%0d", wr_log.size(), uart_Data, cyc, drop_Cnt);
        end
        if (rng_Req) last_req_cyc = cyc;
    end

    // ---------------- UART / RNG responders ----------------
    int         uart_lat = 10, rng_lat = 2;
    bit         rand_lat = 0, spur_en = 0, inj_phase = 0;
    int         inject = 0;
    int         uart_cd = -1, rng_cd = -1;
    logic [7:0] rng_q[$];

    always @(negedge sys_Clk) begin
        uart_Done = 1'b0;
        rng_Valid = 1'b0;
        if (!reset) begin
            uart_cd = -1;
            rng_cd  = -1;
        end else begin
            if (uart_cd > 0) begin
                uart_cd--;
                if (uart_cd == 0) begin
                    uart_Done = 1'b1;
                    uart_cd   = -1;
                end
            end else if (spur_en && $urandom_range(0, 39) == 0) begin
                uart_Done = 1'b1;
            end
            if (uart_Wr) uart_cd = rand_lat ? int'($urandom_range(1, 6)) : uart_lat;

            if (rng_cd > 0) begin
                rng_cd--;
                if (rng_cd == 0) begin
                    rng_Valid = 1'b1;
                    rng_Byte  = (rng_q.size() > 0) ? rng_q.pop_front() : 8'($urandom);
                    rng_cd    = -1;
                end
            end else if (inject > 0) begin
                if (inj_phase) begin
                    rng_Valid = 1'b1;
                    rng_Byte  = 8'hEE;
                    inject--;
                end
                inj_phase = !inj_phase;
            end else if (spur_en && $urandom_range(0, 24) == 0) begin
                rng_Valid = 1'b1;
                rng_Byte  = 8'($urandom);
            end
            if (rng_Req) rng_cd = rand_lat ? int'($urandom_range(1, 5)) : rng_lat;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_log(input int n, input int budget, input string what);
        int k = 0;
        while (wr_log.size() < n && k < budget) begin tick(); k++; end
        if (wr_log.size() < n) begin
            n_checks++; n_fail++;
            $display("FAIL %s: timeout, writes=%0d required=%0d", what, wr_log.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string what);
        int k = 0;
        while (busy && k < budget) begin tick(); k++; end
        check(what, {7'd0, busy}, 8'd0);
    endtask

    task automatic check_frame(input int base, input logic [7:0] e0, e1, e2, e3, e4, e5, input string what);
        logic [7:0] exp[6];
        exp = '{e0, e1, e2, e3, e4, e5};
        for (int i = 0; i < 6; i++)
            check(what, (base + i < wr_log.size()) ? wr_log[base + i] : 8'hXX, exp[i]);
    endtask

    task automatic wait_b1(input int which, input string what);
        int k = 0;
        while (!(which == 0 ? b1_wr : b1_req) && k < 40) begin tick(); k++; end
        check(what, {7'd0, (which == 0 ? b1_wr : b1_req)}, 8'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base, press_cyc;
        reset = 1'b0; button = 1'b0;
        b1_button = 1'b0; b1_valid = 1'b0; b1_done = 1'b0; b1_byte = 8'h00;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_uart_Wr", {7'd0, uart_Wr}, 8'd0);
        check("rst_rng_Req", {7'd0, rng_Req}, 8'd0);
        check("rst_data",    uart_Data, 8'd0);
        check("rst_busy",    {7'd0, busy}, 8'd0);
        check("rst_drop",    drop_Cnt, 8'd0);

        // Frame 1: fixed bytes, UART latency 10, three unrequested bytes during header wait
        uart_lat = 10; rng_lat = 2;
        rng_q = '{8'h11, 8'h22, 8'h44, 8'h88};
        repeat (2) tick();
        base = wr_log.size();
        button = 1'b1;
        press_cyc = cyc;
        wait_log(base + 1, 20, "hdr_timeout");
        check("start_latency", 8'(last_wr_cyc - press_cyc), 8'd2);
        check("hdr_value", uart_Data, 8'hA5);
        tick();
        check("hdr_one_cycle", {7'd0, uart_Wr}, 8'd0);
        button = 1'b0;
        inject = 3;
        begin
            int k = 0;
            while (!rng_Req && k < 40) begin tick(); k++; end
        end
        check("req_seen", {7'd0, rng_Req}, 8'd1);
        check("req_after_done", 8'(cyc - last_done_edge), 8'd1);
        wait_log(base + 6, 200, "frame1_timeout");
        wait_idle(40, "frame1_idle");
        check_frame(base, 8'hA5, 8'h11, 8'h22, 8'h44, 8'h88, 8'hFF, "frame1_bytes");
        check("frame1_drops", drop_Cnt, 8'd3);

        // Frame 2: re-presses while busy are ignored
        uart_lat = 3;
        rng_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        base = wr_log.size();
        button = 1'b1; tick();
        wait_log(base + 1, 20, "frame2_hdr");
        button = 1'b0; repeat (2) tick();
        button = 1'b1; tick(); button = 1'b0;
        wait_log(base + 3, 60, "frame2_mid");
        button = 1'b1; tick(); button = 1'b0;
        wait_log(base + 6, 100, "frame2_timeout");
        wait_idle(40, "frame2_idle");
        repeat (30) tick();
        check("no_extra_writes", 8'(wr_log.size() - base), 8'd6);
        check_frame(base, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, "frame2_bytes");

        // Frame 2b: new press after idle restarts the checksum
        rng_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        base = wr_log.size();
        button = 1'b1; tick(); button = 1'b0;
        wait_log(base + 6, 100, "frame2b_timeout");
        wait_idle(40, "frame2b_idle");
        check_frame(base, 8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40, "frame2b_bytes");

        // Frame 3: reset in SEND_WAIT of byte 2 with button held
        uart_lat = 6;
        base = wr_log.size();
        button = 1'b1;
        wait_log(base + 3, 80, "frame3_mid");
        repeat (2) tick();
        reset = 1'b0; tick(); reset = 1'b1;
        check("mid_rst_uart_Wr", {7'd0, uart_Wr}, 8'd0);
        check("mid_rst_rng_Req", {7'd0, rng_Req}, 8'd0);
        check("mid_rst_data",    uart_Data, 8'd0);
        check("mid_rst_busy",    {7'd0, busy}, 8'd0);
        check("mid_rst_drop",    drop_Cnt, 8'd0);
        repeat (20) tick();
        check("held_no_retrigger", 8'(wr_log.size() - base), 8'd3);
        check("held_idle", {7'd0, busy}, 8'd0);
        button = 1'b0; repeat (2) tick();
        base = wr_log.size();
        button = 1'b1; tick(); button = 1'b0;
        wait_log(base + 6, 120, "frame3b_timeout");
        wait_idle(40, "frame3b_idle");
        check("frame3b_hdr", wr_log[base], 8'hA5);

        // Randomised phase: random latencies, spurious pulses, button toggles, rare resets
        rand_lat = 1; spur_en = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) button = ~button;
            reset = ($urandom_range(0, 999) != 0);
            tick();
        end
        reset = 1'b1; button = 1'b0; spur_en = 0;
        wait_idle(400, "random_drain");

        // BURST_LEN=1 instance: zero byte, coincident done and valid
        b1_button = 1'b1; tick(); b1_button = 1'b0;
        wait_b1(0, "b1_hdr_wr");
        check("b1_hdr", b1_data, 8'hA5);
        b1_done = 1'b1; tick(); b1_done = 1'b0;
        wait_b1(1, "b1_req");
        b1_valid = 1'b1; b1_byte = 8'h00; tick(); b1_valid = 1'b0;
        wait_b1(0, "b1_data_wr");
        check("b1_data", b1_data, 8'h00);
        b1_done = 1'b1; b1_valid = 1'b1; b1_byte = 8'h77; tick();
        b1_done = 1'b0; b1_valid = 1'b0;
        check("b1_coincident_drop", b1_drop, 8'd1);
        wait_b1(0, "b1_csum_wr");
        check("b1_csum", b1_data, 8'h00);
        check("b1_busy_in_csum", {7'd0, b1_busy}, 8'd1);
        b1_done = 1'b1; tick(); b1_done = 1'b0;
        tick();
        check("b1_busy_falls", {7'd0, b1_busy}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
